// File: rtl/core_memory_if.sv
// core_memory_if: execute-side, data-bus and writeback-side signals of the memory stage; w_misalign exists only with CORE_MISALIGN_CHECK_EN
interface core_memory_if #(parameter int XLEN = 32);
  logic m_valid, m_ready;
  logic [XLEN-1:0] m_pc, m_imm, m_alu_out, m_store_data;
  logic [4:0] m_rd;
  logic m_reg_wen, m_mem_rd, m_mem_wr;
  logic [2:0] m_reg_wsel, m_mem_type;
  logic dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
  logic [XLEN-1:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0] dbus_be;
  logic w_valid, w_ready;
  logic [XLEN-1:0] w_pc, w_imm, w_alu_out, w_mem_rdata;
  logic [4:0] w_rd;
  logic w_reg_wen;
  logic [2:0] w_reg_wsel, w_mem_type;
`ifdef CORE_MISALIGN_CHECK_EN
  logic w_misalign;
`endif
  modport slave (
`ifdef CORE_MISALIGN_CHECK_EN
    output w_misalign,
`endif
    input m_valid, m_pc, m_imm, m_alu_out, m_store_data, m_rd, m_reg_wen, m_reg_wsel, m_mem_type, m_mem_rd, m_mem_wr,
    output m_ready,
    output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    input dbus_gnt, dbus_rvalid, dbus_rdata,
    output w_valid, w_pc, w_imm, w_alu_out, w_mem_rdata, w_rd, w_reg_wen, w_reg_wsel, w_mem_type,
    input w_ready
  );
  modport master (
`ifdef CORE_MISALIGN_CHECK_EN
    input w_misalign,
`endif
    output m_valid, m_pc, m_imm, m_alu_out, m_store_data, m_rd, m_reg_wen, m_reg_wsel, m_mem_type, m_mem_rd, m_mem_wr,
    input m_ready,
    input dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    output dbus_gnt, dbus_rvalid, dbus_rdata,
    input w_valid, w_pc, w_imm, w_alu_out, w_mem_rdata, w_rd, w_reg_wen, w_reg_wsel, w_mem_type,
    output w_ready
  );
endinterface

// File: rtl/core_memory.sv
// core_memory: pipeline memory stage issuing load/store data-bus requests; CORE_MISALIGN_CHECK_EN adds misaligned-access bypass with w_misalign
module core_memory #(parameter int XLEN = 32) (
  input logic clk,
  input logic rst,
  core_memory_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0] pc_q, imm_q, alu_q, sdata_q, rdata_q;
  logic [4:0] rd_q;
  logic reg_wen_q, mem_wr_q;
  logic [2:0] wsel_q, type_q;
  logic accept, is_mem, skip;
  assign accept = bus.m_valid && bus.m_ready;
  assign is_mem = bus.m_mem_rd || bus.m_mem_wr;
`ifdef CORE_MISALIGN_CHECK_EN
  logic misalign_q;
  assign skip = is_mem && ((bus.m_mem_type[1:0] == 2'b01 && bus.m_alu_out[0]) ||
                           (bus.m_mem_type[1:0] == 2'b10 && bus.m_alu_out[1:0] != 2'b00));
  assign bus.w_misalign = misalign_q;
`else
  assign skip = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state: a write (even with read also set) never waits for a response
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FULL: state_nx = accept ? ((is_mem && !skip) ? REQ : FULL) : (state == FULL && bus.w_ready) ? IDLE : state;
      REQ: state_nx = bus.dbus_gnt ? (mem_wr_q ? FULL : WAIT) : REQ;
      WAIT: state_nx = bus.dbus_rvalid ? FULL : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  // outputs: handshakes from state, bus lanes steered by the low address bits
  always_comb begin
    bus.m_ready = state == IDLE || (state == FULL && bus.w_ready);
    bus.w_valid = state == FULL;
    bus.dbus_req = state == REQ;
    bus.dbus_we = mem_wr_q;
    bus.dbus_addr = {alu_q[XLEN-1:2], 2'b00};
    bus.dbus_be = !mem_wr_q ? 4'b0000 : type_q[1:0] == 2'b00 ? 4'b0001 << alu_q[1:0] :
                  type_q[1:0] == 2'b01 ? 4'b0011 << alu_q[1:0] : 4'b1111;
    bus.dbus_wdata = type_q[1:0] == 2'b00 ? {4{sdata_q[7:0]}} : type_q[1:0] == 2'b01 ? {2{sdata_q[15:0]}} : sdata_q;
    bus.w_pc = pc_q;
    bus.w_imm = imm_q;
    bus.w_alu_out = alu_q;
    bus.w_mem_rdata = rdata_q;
    bus.w_rd = rd_q;
    bus.w_reg_wen = reg_wen_q;
    bus.w_reg_wsel = wsel_q;
    bus.w_mem_type = type_q;
  end
  // instruction fields captured on accept, load data captured only while waiting
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q <= '0;
      imm_q <= '0;
      alu_q <= '0;
      sdata_q <= '0;
      rdata_q <= '0;
      rd_q <= '0;
      reg_wen_q <= 1'b0;
      mem_wr_q <= 1'b0;
      wsel_q <= '0;
      type_q <= '0;
`ifdef CORE_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        pc_q <= bus.m_pc;
        imm_q <= bus.m_imm;
        alu_q <= bus.m_alu_out;
        sdata_q <= bus.m_store_data;
        rd_q <= bus.m_rd;
        reg_wen_q <= bus.m_reg_wen;
        mem_wr_q <= bus.m_mem_wr;
        wsel_q <= bus.m_reg_wsel;
        type_q <= bus.m_mem_type;
`ifdef CORE_MISALIGN_CHECK_EN
        misalign_q <= skip;
`endif
      end
      if (state == WAIT && bus.dbus_rvalid) rdata_q <= bus.dbus_rdata;
    end
endmodule

// File: tb/tb_core_memory.sv
// tb_core_memory: directed checks of ALU, store, load, back-pressure and reset behaviour
module tb_core_memory;
  logic clk = 1'b0, rst = 1'b1;
  int total = 0, passed = 0;
  core_memory_if bus ();
  core_memory dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic issue(input logic [31:0] pc, alu, sd, input logic [2:0] ty, input logic rd_en, wr_en);
    bus.m_valid = 1'b1;
    bus.m_pc = pc;
    bus.m_imm = pc + 32'd4;
    bus.m_alu_out = alu;
    bus.m_store_data = sd;
    bus.m_rd = 5'd3;
    bus.m_reg_wen = 1'b1;
    bus.m_reg_wsel = 3'd2;
    bus.m_mem_type = ty;
    bus.m_mem_rd = rd_en;
    bus.m_mem_wr = wr_en;
  endtask
  initial begin
    bus.m_valid = 0; bus.m_pc = 0; bus.m_imm = 0; bus.m_alu_out = 0; bus.m_store_data = 0;
    bus.m_rd = 0; bus.m_reg_wen = 0; bus.m_reg_wsel = 0; bus.m_mem_type = 0; bus.m_mem_rd = 0; bus.m_mem_wr = 0;
    bus.dbus_gnt = 0; bus.dbus_rvalid = 0; bus.dbus_rdata = 0; bus.w_ready = 1;
    #12;
    check("rst_w_valid", bus.w_valid, 0);
    check("rst_dbus_req", bus.dbus_req, 0);
    check("rst_m_ready", bus.m_ready, 1);
    check("rst_w_alu_out", bus.w_alu_out, 0);
    @(negedge clk) rst = 0;
    // ALU op
    @(negedge clk) issue(32'h100, 32'h55, 0, 3'b010, 0, 0);
    #1 check("alu_m_ready", bus.m_ready, 1);
    @(negedge clk) bus.m_valid = 0;
    check("alu_w_valid", bus.w_valid, 1);
    check("alu_w_alu_out", bus.w_alu_out, 32'h55);
    check("alu_w_pc", bus.w_pc, 32'h100);
    check("alu_w_imm", bus.w_imm, 32'h104);
    check("alu_w_rd", bus.w_rd, 3);
    check("alu_dbus_req", bus.dbus_req, 0);
    @(negedge clk) check("alu_idle", bus.w_valid, 0);
    // SB to 0x1003, grant after 2 cycles
    issue(32'h104, 32'h1003, 32'hAB, 3'b000, 0, 1);
    @(negedge clk) bus.m_valid = 0;
    check("sb_req", bus.dbus_req, 1);
    check("sb_we", bus.dbus_we, 1);
    check("sb_addr", bus.dbus_addr, 32'h1000);
    check("sb_be", bus.dbus_be, 4'b1000);
    check("sb_wdata", bus.dbus_wdata, 32'hABABABAB);
    check("sb_w_valid", bus.w_valid, 0);
    @(negedge clk) check("sb_req_held", bus.dbus_req, 1);
    check("sb_addr_held", bus.dbus_addr, 32'h1000);
    bus.dbus_gnt = 1;
    @(negedge clk) bus.dbus_gnt = 0;
    check("sb_done", bus.w_valid, 1);
    check("sb_req_off", bus.dbus_req, 0);
    // LW 0x2000, immediate grant, rvalid 3 cycles after grant
    @(negedge clk) issue(32'h108, 32'h2000, 0, 3'b010, 1, 0);
    bus.dbus_gnt = 1;
    @(negedge clk) bus.m_valid = 0;
    check("lw_req", bus.dbus_req, 1);
    check("lw_we", bus.dbus_we, 0);
    check("lw_be", bus.dbus_be, 0);
    check("lw_addr", bus.dbus_addr, 32'h2000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk) bus.dbus_gnt = 0;
      check("lw_wait", bus.w_valid, 0);
      check("lw_wait_req", bus.dbus_req, 0);
    end
    @(negedge clk) bus.dbus_rvalid = 1;
    bus.dbus_rdata = 32'hDEADBEEF;
    check("lw_wait3", bus.w_valid, 0);
    @(negedge clk) bus.dbus_rvalid = 0;
    check("lw_w_valid", bus.w_valid, 1);
    check("lw_rdata", bus.w_mem_rdata, 32'hDEADBEEF);
    // SH with rd and wr both set acts as store
    @(negedge clk) issue(32'h10C, 32'h1002, 32'h00001234, 3'b001, 1, 1);
    bus.dbus_gnt = 1;
    @(negedge clk) bus.m_valid = 0;
    check("sh_we", bus.dbus_we, 1);
    check("sh_be", bus.dbus_be, 4'b1100);
    check("sh_wdata", bus.dbus_wdata, 32'h12341234);
    @(negedge clk) bus.dbus_gnt = 0;
    check("sh_w_valid", bus.w_valid, 1);
    // back-to-back ALU ops then 2 cycles of back-pressure
    @(negedge clk) issue(32'h200, 32'h10, 0, 3'b010, 0, 0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk) issue(32'h200 + i * 4, 32'h10 + i, 0, 3'b010, 0, 0);
      #1 check("b2b_m_ready", bus.m_ready, 1);
      check("b2b_w_valid", bus.w_valid, 1);
      check("b2b_w_alu_out", bus.w_alu_out, 32'h10 + i - 1);
    end
    @(negedge clk) issue(32'h210, 32'h14, 0, 3'b010, 0, 0);
    bus.w_ready = 0;
    for (int i = 0; i < 2; i++) begin
      #1 check("stall_m_ready", bus.m_ready, 0);
      check("stall_w_valid", bus.w_valid, 1);
      check("stall_w_alu_out", bus.w_alu_out, 32'h13);
      @(negedge clk);
    end
    bus.w_ready = 1;
    @(negedge clk) bus.m_valid = 0;
    check("resume_w_alu_out", bus.w_alu_out, 32'h14);
    check("resume_w_valid", bus.w_valid, 1);
    @(negedge clk) check("resume_idle", bus.w_valid, 0);
    // reset while waiting for a load response, then a stale rvalid
    issue(32'h300, 32'h4000, 0, 3'b010, 1, 0);
    bus.dbus_gnt = 1;
    @(negedge clk) bus.m_valid = 0;
    @(negedge clk) bus.dbus_gnt = 0;
    check("rw_wait_m_ready", bus.m_ready, 0);
    #2 rst = 1;
    #1 check("rw_rst_m_ready", bus.m_ready, 1);
    check("rw_rst_w_valid", bus.w_valid, 0);
    @(negedge clk) rst = 0;
    bus.dbus_rvalid = 1;
    bus.dbus_rdata = 32'h12345678;
    @(negedge clk) bus.dbus_rvalid = 0;
    check("rw_stale_w_valid", bus.w_valid, 0);
    check("rw_stale_m_ready", bus.m_ready, 1);
    check("rw_stale_rdata", bus.w_mem_rdata, 0);
    check("rw_stale_req", bus.dbus_req, 0);
`ifdef CORE_MISALIGN_CHECK_EN
    @(negedge clk) issue(32'h400, 32'h3001, 0, 3'b001, 1, 0);
    @(negedge clk) bus.m_valid = 0;
    check("mis_req", bus.dbus_req, 0);
    check("mis_w_valid", bus.w_valid, 1);
    check("mis_flag", bus.w_misalign, 1);
`endif
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/core_memory.md
CORE_MEMORY -- requirements
Module: core_memory

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data/address width; only 32 is supported.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  SHALL be asynchronous and active-high; assertion immediately forces reset state.
REQ-004 m_valid  in  1  execute-side instruction valid.
REQ-005 m_ready  out  1  memory stage accepts instruction this cycle.
REQ-006 m_pc, m_imm, m_alu_out, m_store_data  in  32 each  instruction fields; m_alu_out is the memory address.
REQ-007 m_rd  in  5; m_reg_wen  in  1; m_reg_wsel  in  3; m_mem_type  in  3 (000 B, 001 H, 010 W, 100 BU, 101 HU); m_mem_rd, m_mem_wr  in  1 each.
REQ-008 dbus_req  out  1; dbus_we  out  1; dbus_addr  out  32 (word-aligned); dbus_be  out  4; dbus_wdata  out  32.
REQ-009 dbus_gnt  in  1  request accepted; dbus_rvalid  in  1; dbus_rdata  in  32  load response.
REQ-010 w_valid  out  1; w_ready  in  1; w_pc, w_imm, w_alu_out, w_mem_rdata  out  32; w_rd  out  5; w_reg_wen  out  1; w_reg_wsel  out  3; w_mem_type  out  3.

Function
REQ-011 FSM states SHALL be IDLE, REQ, WAIT, FULL.
REQ-012 m_ready SHALL be 1 in IDLE, and in FULL when w_ready=1; 0 otherwise.
REQ-013 On m_valid&&m_ready, all m_* fields SHALL be registered; next state REQ if m_mem_rd or m_mem_wr, else FULL.
REQ-014 In REQ, dbus_req SHALL be 1 with dbus_we=registered m_mem_wr and dbus_addr={alu_out[31:2],2'b00}; outputs stable until dbus_gnt.
REQ-015 Store byte lanes: B -> be=4'b0001<<off, wdata=byte replicated x4; H -> be=4'b0011<<off, wdata=half replicated x2; W -> be=4'b1111, wdata=data; off=alu_out[1:0]; dbus_be=0 for loads.
REQ-016 REQ with dbus_gnt: store -> FULL (no response awaited); load -> WAIT.
REQ-017 WAIT with dbus_rvalid: dbus_rdata SHALL be captured raw into w_mem_rdata; next FULL. dbus_rvalid in any other state SHALL be ignored.
REQ-018 In FULL, w_valid SHALL be 1 and w_* SHALL show registered fields; on w_ready with m_valid, new instruction accepted same cycle (REQ-013); on w_ready without m_valid -> IDLE.
REQ-019 Latency: non-memory op accepted cycle N -> w_valid cycle N+1; sustained throughput one op per cycle when w_ready=1.
REQ-020 Load with gnt in cycle G and rvalid in cycle R (R>G) SHALL give w_valid in R+1.
REQ-021 w_valid=0 SHALL hold in IDLE, REQ, WAIT; w_* values then are don't-care but SHALL not be X after reset.
REQ-022 m_mem_rd and m_mem_wr both set SHALL be treated as store.

Reset
REQ-023 Reset SHALL force IDLE, w_valid=0, dbus_req=0, m_ready=1 (combinationally after reset), and all registered fields to 0.
REQ-024 Reset during REQ/WAIT SHALL abandon the transaction; a later stale dbus_rvalid in IDLE SHALL be ignored.

Configuration
REQ-025 Macro CORE_MISALIGN_CHECK_EN defined: H with off[0]=1 or W with off!=0 SHALL skip REQ, go directly to FULL with added output w_misalign=1 (1 bit), dbus_req never asserted.
REQ-026 Macro undefined: no w_misalign port; low address bits SHALL only steer lanes per REQ-015, misalignment unchecked.

Verification
REQ-027 ALU op pc=0x100, alu_out=0x55, w_ready=1 -> w_valid next cycle, w_alu_out=0x55, no dbus_req.
REQ-028 SB data=0x000000AB addr=0x1003, gnt after 2 cycles -> dbus_addr=0x1000, be=4'b1000, wdata=0xABABABAB, w_valid cycle after gnt.
REQ-029 LW addr=0x2000, gnt immediate, rvalid 3 cycles later with 0xDEADBEEF -> w_mem_rdata=0xDEADBEEF, w_valid cycle after rvalid.
REQ-030 Back-to-back 4 ALU ops, w_ready=1 -> 4 consecutive w_valid cycles; w_ready=0 for 2 cycles -> w_* held, m_ready=0.
REQ-031 rst asserted in WAIT, then rvalid pulse -> state IDLE, w_valid stays 0, pulse ignored.
REQ-032 With CORE_MISALIGN_CHECK_EN, LH addr=0x3001 -> no dbus_req, w_valid next cycle, w_misalign=1.
